// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, state encodings, select codes and the control word for the multicycle MIPS controller
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;
  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  endfunction
endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: combinational state/bne_q/zero -> datapath control word
module ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_bne_q,
  input  logic   i_zero,
  input  logic   i_ready,
  output ctrl_t  o_ctrl
);
  logic w_pc_write;
  logic w_pc_cond;
  // Moore decode; pc_en folds in the branch condition, FETCH commits only when memory is ready
  always_comb begin
    o_ctrl     = '0;
    w_pc_write = 1'b0;
    w_pc_cond  = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = i_ready;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_OP_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        w_pc_write       = i_ready;
      end
      S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_ADDIWB: o_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_OP_SUB;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
        w_pc_cond        = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_src = PCSRC_JUMP;
        w_pc_write    = 1'b1;
      end
      default: ;
    endcase
    o_ctrl.pc_en = w_pc_write | (w_pc_cond & (i_zero ^ i_bne_q));
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle MIPS datapath; MULTICYCLE_MEM_WAIT_EN adds mem_ready wait states
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int OP_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);
  state_t     r_state;
  state_t     w_next;
  logic       r_bne_q;
  logic       r_sw;
  logic       w_ready;
  logic [5:0] w_op;
  ctrl_t      w_ctrl;
`ifdef MULTICYCLE_MEM_WAIT_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1;
`endif
  assign w_op       = 6'(opcode);
  assign state_o    = STATE_W'(r_state);
  assign illegal_op = (r_state == S_DECODE) & ~op_legal(w_op);
  // State register; bne/sw flavour captured in DECODE since opcode is only valid there
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_bne_q <= 1'b0;
      r_sw    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_bne_q <= w_op == OP_BNE;
        r_sw    <= w_op == OP_SW;
      end
    end
  end
  // Next-state logic; write-back, branch, jump and unused encodings all return to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (w_op == OP_RTYPE)                   ? S_EXEC   :
                         (w_op == OP_LW  || w_op == OP_SW)    ? S_MEMADR :
                         (w_op == OP_BEQ || w_op == OP_BNE)   ? S_BRANCH :
                         (w_op == OP_ADDI)                    ? S_ADDIEX :
                         (w_op == OP_J)                       ? S_JUMP   : S_FETCH;
      S_MEMADR: w_next = r_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end
  ctrl_out_decode u_dec (
    .i_state (r_state),
    .i_bne_q (r_bne_q),
    .i_zero  (zero),
    .i_ready (w_ready),
    .o_ctrl  (w_ctrl)
  );
  assign {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
          alu_src_a, alu_src_b, alu_op, pc_src} = w_ctrl;
endmodule
